// File: rtl/mig_cmd_sched.sv
// mig_cmd_sched: pops read/write requests from a queue and issues them to a MIG app port,
// limiting reads in flight. Latency: 3 cycles per read (IDLE, RCMD, POP), 4+ cycles per write.
// Backpressure: holds app_en / app_wdf_wren until app_rdy / app_wdf_rdy; stalls reads at MAXRD in flight.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   init_calib_complete           gates new command starts only
//   rqempty, qraddr, rd_bwt       request queue head; rnext pops it (one-cycle pulse in POP)
//   wdata, wdata_pop              write-data buffer head and its consume pulse
//   app_*                         MIG app command, write-data and read-data channels
//   rdata, rdata_valid            read data registered by one cycle
//   rd_outstanding, rd_err, busy  reads in flight, sticky underflow flag, FSM not idle
module mig_cmd_sched #(
  parameter int AW    = 28,
  parameter int DW    = 128,
  parameter int MAXRD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init_calib_complete,
  input  logic            rqempty,
  input  logic [31:0]     qraddr,
  input  logic            rd_bwt,
  output logic            rnext,
  input  logic [DW-1:0]   wdata,
  output logic            wdata_pop,
  output logic [AW-1:0]   app_addr,
  output logic [2:0]      app_cmd,
  output logic            app_en,
  input  logic            app_rdy,
  output logic [DW-1:0]   app_wdf_data,
  output logic            app_wdf_wren,
  output logic            app_wdf_end,
  output logic [DW/8-1:0] app_wdf_mask,
  input  logic            app_wdf_rdy,
  input  logic [DW-1:0]   app_rd_data,
  input  logic            app_rd_data_valid,
  input  logic            app_rd_data_end,
  output logic [DW-1:0]   rdata,
  output logic            rdata_valid,
  output logic [2:0]      rd_outstanding,
  output logic            rd_err,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RCMD,
    S_WDAT,
    S_WCMD,
    S_POP
  } state_t;

  localparam logic [2:0] LP_CMD_RD = 3'b001;
  localparam logic [2:0] LP_CMD_WR = 3'b000;
  localparam logic [2:0] LP_MAXRD  = 3'(MAXRD);

  state_t          r_state;
  logic            r_app_en;
  logic [2:0]      r_app_cmd;
  logic [AW-1:0]   r_app_addr;
  logic            r_wdf_wren;
  logic            r_wdf_end;
  logic            r_rnext;
  logic            r_wdata_pop;
  logic            r_busy;
  logic [DW-1:0]   r_rdata;
  logic            r_rdata_valid;
  logic [2:0]      r_rd_out;
  logic            r_rd_err;

  logic            w_rd_acc;
  logic            w_rd_done;
  logic            w_rd_room;
  logic            w_unused_qraddr;

  assign w_rd_acc  = (r_state == S_RCMD) && r_app_en && app_rdy;
  assign w_rd_done = app_rd_data_valid && app_rd_data_end;
  assign w_rd_room = (r_rd_out < LP_MAXRD);
  // Address bits above AW are not used by the MIG.
  assign w_unused_qraddr = ^qraddr;

  // Command FSM; every output it drives is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_app_en    <= 1'b0;
      r_app_cmd   <= 3'b000;
      r_app_addr  <= '0;
      r_wdf_wren  <= 1'b0;
      r_wdf_end   <= 1'b0;
      r_rnext     <= 1'b0;
      r_wdata_pop <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rnext     <= 1'b0;
      r_wdata_pop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (init_calib_complete && !rqempty) begin
            r_app_addr <= qraddr[AW-1:0];
            if (rd_bwt) begin
              // With MAXRD reads in flight the head stays put until data returns.
              if (w_rd_room) begin
                r_state   <= S_RCMD;
                r_app_en  <= 1'b1;
                r_app_cmd <= LP_CMD_RD;
                r_busy    <= 1'b1;
              end
            end else begin
              r_state    <= S_WDAT;
              r_wdf_wren <= 1'b1;
              r_wdf_end  <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
        end
        S_RCMD: begin
          if (app_rdy) begin
            r_app_en <= 1'b0;
            r_rnext  <= 1'b1;
            r_state  <= S_POP;
          end
        end
        S_WDAT: begin
          // Data goes first so the MIG never sees a write command without its data.
          if (app_wdf_rdy) begin
            r_wdf_wren  <= 1'b0;
            r_wdf_end   <= 1'b0;
            r_wdata_pop <= 1'b1;
            r_app_en    <= 1'b1;
            r_app_cmd   <= LP_CMD_WR;
            r_state     <= S_WCMD;
          end
        end
        S_WCMD: begin
          if (app_rdy) begin
            r_app_en <= 1'b0;
            r_rnext  <= 1'b1;
            r_state  <= S_POP;
          end
        end
        S_POP: begin
          // rnext is high for this cycle only; the next head is sampled in IDLE.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Reads in flight: an accept and a return in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_out <= 3'd0;
      r_rd_err <= 1'b0;
    end else begin
      if (w_rd_acc && !w_rd_done) begin
        r_rd_out <= r_rd_out + 3'd1;
      end else if (!w_rd_acc && w_rd_done) begin
        if (r_rd_out == 3'd0) begin
          r_rd_err <= 1'b1;
        end else begin
          r_rd_out <= r_rd_out - 3'd1;
        end
      end
    end
  end

  // Read data pipeline; data register only loads on a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rdata_valid <= app_rd_data_valid;
      if (app_rd_data_valid) begin
        r_rdata <= app_rd_data;
      end
    end
  end

  assign rnext          = r_rnext;
  assign wdata_pop      = r_wdata_pop;
  assign app_addr       = r_app_addr;
  assign app_cmd        = r_app_cmd;
  assign app_en         = r_app_en;
  assign app_wdf_data   = wdata;
  assign app_wdf_wren   = r_wdf_wren;
  assign app_wdf_end    = r_wdf_end;
  assign app_wdf_mask   = '0;
  assign rdata          = r_rdata;
  assign rdata_valid    = r_rdata_valid;
  assign rd_outstanding = r_rd_out;
  assign rd_err         = r_rd_err;
  assign busy           = r_busy;

endmodule

// File: tb/tb_mig_cmd_sched.sv
module tb_mig_cmd_sched;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int MAXRD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            init_calib_complete;
  logic            rqempty;
  logic [31:0]     qraddr;
  logic            rd_bwt;
  logic            rnext;
  logic [DW-1:0]   wdata;
  logic            wdata_pop;
  logic [AW-1:0]   app_addr;
  logic [2:0]      app_cmd;
  logic            app_en;
  logic            app_rdy;
  logic [DW-1:0]   app_wdf_data;
  logic            app_wdf_wren;
  logic            app_wdf_end;
  logic [DW/8-1:0] app_wdf_mask;
  logic            app_wdf_rdy;
  logic [DW-1:0]   app_rd_data;
  logic            app_rd_data_valid;
  logic            app_rd_data_end;
  logic [DW-1:0]   rdata;
  logic            rdata_valid;
  logic [2:0]      rd_outstanding;
  logic            rd_err;
  logic            busy;

  mig_cmd_sched #(.AW(AW), .DW(DW), .MAXRD(MAXRD)) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .rqempty(rqempty), .qraddr(qraddr), .rd_bwt(rd_bwt), .rnext(rnext),
    .wdata(wdata), .wdata_pop(wdata_pop),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end),
    .rdata(rdata), .rdata_valid(rdata_valid), .rd_outstanding(rd_outstanding),
    .rd_err(rd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Request queue model: head drives qraddr/rd_bwt/rqempty, rnext pops it.
  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
  } ent_t;
  ent_t q[$];

  int n_checks = 0;
  int n_errs   = 0;
  int n_rd_en, n_wr_en, n_wren, n_ovl, n_wpop, n_rnext;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic refresh();
    rqempty = (q.size() == 0);
    if (q.size() > 0) begin
      qraddr = q[0].addr;
      rd_bwt = q[0].rd;
    end
  endtask

  task automatic push(input logic [31:0] addr, input logic rd);
    ent_t e;
    e.addr = addr;
    e.rd   = rd;
    q.push_back(e);
    refresh();
  endtask

  task automatic clr_cnt();
    n_rd_en = 0; n_wr_en = 0; n_wren = 0; n_ovl = 0; n_wpop = 0; n_rnext = 0;
  endtask

  // One cycle: wait for the falling edge, tally observed outputs, pop on rnext.
  task automatic step();
    @(negedge clk);
    if (app_en && app_cmd == 3'b001) n_rd_en++;
    if (app_en && app_cmd == 3'b000) n_wr_en++;
    if (app_wdf_wren) n_wren++;
    if (app_wdf_wren && app_en) n_ovl++;
    if (wdata_pop) n_wpop++;
    if (rnext) begin
      n_rnext++;
      if (q.size() > 0) void'(q.pop_front());
    end
    refresh();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},    64'(app_en), 0);
    check({tag, "_cmd"},   64'(app_cmd), 0);
    check({tag, "_addr"},  64'(app_addr), 0);
    check({tag, "_wren"},  64'(app_wdf_wren), 0);
    check({tag, "_wend"},  64'(app_wdf_end), 0);
    check({tag, "_rnext"}, 64'(rnext), 0);
    check({tag, "_wpop"},  64'(wdata_pop), 0);
    check({tag, "_rdata"}, 64'(rdata), 0);
    check({tag, "_rdv"},   64'(rdata_valid), 0);
    check({tag, "_rdout"}, 64'(rd_outstanding), 0);
    check({tag, "_rderr"}, 64'(rd_err), 0);
    check({tag, "_busy"},  64'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; init_calib_complete = 1'b1; rqempty = 1'b1; qraddr = '0; rd_bwt = 1'b0;
    wdata = 32'hCAFE_0001; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data = '0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    clr_cnt();
    step(); step();
    check_all_zero("reset");
    check("mask", 64'(app_wdf_mask), 0);
    rst = 1'b0;
    step();

    // Read issue
    clr_cnt();
    push(32'h0000_1230, 1'b1);
    step();
    check("rd_en", 64'(app_en), 1);
    check("rd_cmd", 64'(app_cmd), 1);
    check("rd_addr", 64'(app_addr), 64'h1230);
    check("rd_busy", 64'(busy), 1);
    check("rd_rnext_early", 64'(rnext), 0);
    step();
    check("rd_en_drop", 64'(app_en), 0);
    check("rd_rnext", 64'(rnext), 1);
    check("rd_out1", 64'(rd_outstanding), 1);
    step();
    check("rd_rnext_clr", 64'(rnext), 0);
    check("rd_idle", 64'(busy), 0);
    check("rd_en_cycles", 64'(n_rd_en), 1);
    // Read data return, then non-valid data must not update rdata
    app_rd_data = 32'hDEAD_BEEF; app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
    step();
    check("rdata", 64'(rdata), 64'hDEAD_BEEF);
    check("rdata_vld", 64'(rdata_valid), 1);
    check("rd_out0", 64'(rd_outstanding), 0);
    app_rd_data = 32'h1111_1111; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    step();
    check("rdata_hold", 64'(rdata), 64'hDEAD_BEEF);
    check("rdata_vld0", 64'(rdata_valid), 0);

    // Write with backpressure
    clr_cnt();
    app_wdf_rdy = 1'b0; app_rdy = 1'b0;
    push(32'h0000_4560, 1'b0);
    step();
    check("wr_wren", 64'(app_wdf_wren), 1);
    check("wr_wend", 64'(app_wdf_end), 1);
    check("wr_wdata", 64'(app_wdf_data), 64'hCAFE_0001);
    step(); step(); step();
    app_wdf_rdy = 1'b1;
    step();
    check("wr_wren_drop", 64'(app_wdf_wren), 0);
    check("wr_en", 64'(app_en), 1);
    check("wr_cmd", 64'(app_cmd), 0);
    check("wr_wpop", 64'(wdata_pop), 1);
    check("wr_addr", 64'(app_addr), 64'h4560);
    step(); step();
    app_rdy = 1'b1;
    step();
    check("wr_rnext", 64'(rnext), 1);
    step();
    check("wr_wren_cycles", 64'(n_wren), 4);
    check("wr_en_cycles", 64'(n_wr_en), 3);
    check("wr_wpops", 64'(n_wpop), 1);
    check("wr_rnexts", 64'(n_rnext), 1);
    check("wr_overlap", 64'(n_ovl), 0);

    // Read limit
    clr_cnt();
    for (int i = 0; i < 5; i++) push(32'h100 + 32'(i), 1'b1);
    for (int i = 0; i < 20; i++) step();
    check("lim_en", 64'(n_rd_en), 4);
    check("lim_out", 64'(rd_outstanding), 4);
    check("lim_busy", 64'(busy), 0);
    check("lim_qlen", 64'(q.size()), 1);
    app_rd_data = 32'h5A5A_5A5A; app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
    step();
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("lim_en5", 64'(n_rd_en), 5);
    check("lim_out4", 64'(rd_outstanding), 4);
    check("lim_addr5", 64'(app_addr), 64'h104);
    check("lim_qempty", 64'(q.size()), 0);

    // Simultaneous accept and return at 2 in flight
    app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
    step(); step();
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    step();
    check("sim_pre", 64'(rd_outstanding), 2);
    push(32'h200, 1'b1);
    step();
    check("sim_en", 64'(app_en), 1);
    app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
    step();
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    check("sim_out", 64'(rd_outstanding), 2);
    check("sim_rnext", 64'(rnext), 1);
    step();
    // Underflow
    app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
    step(); step();
    check("uf_out0", 64'(rd_outstanding), 0);
    check("uf_noerr", 64'(rd_err), 0);
    step();
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    check("uf_err", 64'(rd_err), 1);
    check("uf_out", 64'(rd_outstanding), 0);
    step();
    check("uf_sticky", 64'(rd_err), 1);

    // Calibration gate
    clr_cnt();
    init_calib_complete = 1'b0;
    push(32'h300, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check("cal_en", 64'(n_wr_en + n_rd_en), 0);
    check("cal_wren", 64'(n_wren), 0);
    check("cal_rnext", 64'(n_rnext), 0);
    check("cal_busy", 64'(busy), 0);
    init_calib_complete = 1'b1; app_rdy = 1'b0;
    step();
    check("cal_wdat", 64'(app_wdf_wren), 1);
    step();
    check("cal_wcmd", 64'(app_en), 1);
    init_calib_complete = 1'b0;
    step(); step();
    app_rdy = 1'b1;
    step();
    check("cal_drop_rnext", 64'(rnext), 1);
    step();
    check("cal_rnexts", 64'(n_rnext), 1);
    check("cal_qempty", 64'(q.size()), 0);
    init_calib_complete = 1'b1;

    // Reset mid-command
    clr_cnt();
    app_rdy = 1'b0;
    push(32'h0000_2468, 1'b1);
    step();
    check("rm_en", 64'(app_en), 1);
    rst = 1'b1;
    step();
    check_all_zero("rm");
    check("rm_qlen", 64'(q.size()), 1);
    rst = 1'b0; app_rdy = 1'b1;
    step();
    check("rm_reissue", 64'(app_en), 1);
    check("rm_addr", 64'(app_addr), 64'h2468);
    step();
    check("rm_rnext", 64'(rnext), 1);
    step();
    check("rm_rnexts", 64'(n_rnext), 1);
    check("rm_wpops", 64'(n_wpop), 0);
    check("rm_qempty", 64'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/mig_cmd_sched.md
MIG_CMD_SCHED -- requirements
Module: mig_cmd_sched

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst; all state SHALL update on the rising edge of clk.
REQ-002 Parameters SHALL be:
- AW, default 28: MIG app address width.
- DW, default 128: MIG data width.
- MAXRD, default 4: maximum number of reads in flight, range 1..7.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- init_calib_complete, in, 1: MIG calibration done.
- rqempty, in, 1: request queue empty.
- qraddr, in, 32: address at the queue head.
- rd_bwt, in, 1: queue head is a read when 1, a write when 0.
- rnext, out, 1: one-cycle pulse that pops the queue head.
- wdata, in, DW: write-data buffer head.
- wdata_pop, out, 1: one-cycle pulse that consumes the write-data buffer head.
- app_addr, out, AW: MIG address.
- app_cmd, out, 3: MIG command; 3'b001 read, 3'b000 write.
- app_en, out, 1: command valid.
- app_rdy, in, 1: command accepted.
- app_wdf_data, out, DW: write data, equal to wdata.
- app_wdf_wren, out, 1: write data valid.
- app_wdf_end, out, 1: last beat of write data.
- app_wdf_mask, out, DW/8: byte mask, constant 0.
- app_wdf_rdy, in, 1: write data accepted.
- app_rd_data, in, DW: MIG read data.
- app_rd_data_valid, in, 1: read data valid.
- app_rd_data_end, in, 1: last beat of read data.
- rdata, out, DW: registered read data.
- rdata_valid, out, 1: registered read-data valid.
- rd_outstanding, out, 3: number of reads in flight.
- rd_err, out, 1: sticky read-data underflow flag.
- busy, out, 1: state machine is not in IDLE.

Function
REQ-004 State machine states SHALL be IDLE, RCMD, WDAT, WCMD and POP, and the reset state SHALL be IDLE.
REQ-005 In IDLE with init_calib_complete=1 and rqempty=0, the block SHALL latch app_addr<=qraddr[AW-1:0] and take exactly one of the following actions:
- rd_bwt=1 and rd_outstanding<MAXRD: go to RCMD with app_en<=1 and app_cmd<=3'b001.
- rd_bwt=1 and rd_outstanding==MAXRD: stay in IDLE with no MIG activity (stall).
- rd_bwt=0: go to WDAT with app_wdf_wren<=1 and app_wdf_end<=1.
REQ-006 In RCMD, the block SHALL hold app_en, app_cmd and app_addr stable until app_rdy=1; on the cycle where app_en&app_rdy, it SHALL clear app_en, increment rd_outstanding and go to POP.
REQ-007 In WDAT, the block SHALL hold app_wdf_wren=1 and app_wdf_end=1 until app_wdf_rdy=1; on acceptance it SHALL:
- clear app_wdf_wren and app_wdf_end;
- pulse wdata_pop for exactly one cycle (registered, in the next cycle);
- go to WCMD with app_en<=1 and app_cmd<=3'b000.
REQ-008 In WCMD, the block SHALL hold app_en until app_rdy=1, then clear app_en and go to POP.
REQ-009 POP SHALL last exactly one cycle, SHALL assert rnext=1 during that cycle, and SHALL return to IDLE; rnext SHALL be 0 in every other state.
REQ-010 The minimum issue interval SHALL be 3 cycles per read (IDLE, RCMD, POP) and 4 cycles per write, so the queue head is never sampled before the pop takes effect.
REQ-011 rd_outstanding SHALL follow these rules on each cycle:
- +1 on read command acceptance.
- -1 on app_rd_data_valid&app_rd_data_end.
- Unchanged when both events occur in the same cycle.
- Never wraps.
REQ-012 If app_rd_data_valid&app_rd_data_end occurs while rd_outstanding==0, the counter SHALL stay at 0 and rd_err SHALL set and stay set until reset.
REQ-013 rdata and rdata_valid SHALL equal app_rd_data and app_rd_data_valid delayed by exactly one cycle; rdata SHALL be updated only when app_rd_data_valid=1.
REQ-014 If init_calib_complete drops mid-operation, the in-progress command SHALL complete; init_calib_complete gates only new starts from IDLE.
REQ-015 app_addr SHALL remain stable from the latch in IDLE through POP; changes on qraddr or rd_bwt outside IDLE SHALL be ignored.
REQ-016 app_wdf_mask SHALL be constant 0, and app_wdf_data SHALL equal wdata combinationally.
REQ-017 busy SHALL be 1 in every state except IDLE.

Reset
REQ-018 On rst=1, the block SHALL, at the next edge:
- go to IDLE;
- clear app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, rnext, wdata_pop, rdata, rdata_valid, rd_outstanding, rd_err and busy to 0.
REQ-019 A reset asserted mid-command SHALL abandon that command without a rnext or wdata_pop pulse, and the queue entry SHALL remain unpopped.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Read issue: queue head read, qraddr=0x0000_1230, app_rdy=1 always -> app_en=1 with app_cmd=001 and app_addr=0x1230 for 1 cycle, rnext pulses 2 cycles after IDLE start, rd_outstanding=1.
- Write with backpressure: head write, app_wdf_rdy low 3 cycles then high, app_rdy low 2 cycles -> app_wdf_wren high 4 cycles, one wdata_pop, app_en high 3 cycles with app_cmd=000, one rnext, no overlap of wren and app_en.
- Read limit: 5 consecutive reads, no read data returned, MAXRD=4 -> exactly 4 app_en read pulses, rd_outstanding=4, busy=0 and stalled; one app_rd_data_valid&end -> 5th read issues.
- Simultaneous events: read accept in the same cycle as read-data end, with rd_outstanding=2 -> stays 2; data end with rd_outstanding=0 -> rd_err=1, counter 0.
- Calibration gate: init_calib_complete=0 with a non-empty queue -> no app_en, no rnext; drop calibration during WCMD -> write completes and rnext pulses.
- Reset mid-op: rst asserted in RCMD with app_rdy=0 -> next cycle all outputs 0, no rnext, and the same entry reissues after reset release.
